mealy_out_packer: RTL and testbench

//   Downstream consumer of the Mealy detector's 1-bit `out` stream. Samples one bit per

---
 rtl/mealy_out_packer.sv | 95 +++++++++
 tb/tb_mealy_out_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mealy_out_packer.sv
// Packs the Mealy detector's 1-bit output stream MSB-first into WIDTH-bit words.
// Words leave on a valid/ready port; lifetime hit count saturates.
module mealy_out_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  output logic [WIDTH-1:0]             word_data,
  output logic [$clog2(WIDTH+1)-1:0]   word_ones,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [CNT_W-1:0]             hit_total,
  output logic                         overflow,
  output logic [1:0]                   fill_state
);

  localparam int OW = $clog2(WIDTH+1);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [OW-1:0]    ones_acc;

  logic [WIDTH-1:0] word_next;
  logic [OW-1:0]    ones_next;
  logic             out_free;

  always_comb begin
    word_next = {shreg, in_bit};
    ones_next = ones_acc + OW'(in_bit);
    out_free  = !word_valid || word_ready;
  end

  assign fill_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      shreg      <= '0;
      bit_cnt    <= '0;
      ones_acc   <= '0;
      word_data  <= '0;
      word_ones  <= '0;
      word_valid <= 1'b0;
      hit_total  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (word_valid && word_ready)
        word_valid <= 1'b0;
      if (in_valid) begin
        shreg <= word_next[WIDTH-2:0];
        if (in_bit && hit_total != '1)
          hit_total <= hit_total + CNT_W'(1);
        unique case (state)
          EMPTY: begin
            bit_cnt  <= CW'(1);
            ones_acc <= OW'(in_bit);
            state    <= (WIDTH == 2) ? LAST : FILL;
          end
          FILL: begin
            bit_cnt  <= bit_cnt + CW'(1);
            ones_acc <= ones_next;
            if (bit_cnt == CW'(WIDTH-2))
              state <= LAST;
          end
          LAST: begin
            bit_cnt  <= '0;
            ones_acc <= '0;
            state    <= EMPTY;
            // a held word that is not being accepted wins; the new one is lost
            if (out_free) begin
              word_data  <= word_next;
              word_ones  <= ones_next;
              word_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mealy_out_packer.sv
// Directed bench for mealy_out_packer: packing, handshake, overflow,
// reset priority and hit counter saturation.
module tb_mealy_out_packer;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_bit, word_ready;
  logic [7:0] word_data;
  logic [3:0] word_ones;
  logic       word_valid, overflow;
  logic [7:0] hit_total;
  logic [1:0] fill_state;

  logic       rst4, in_valid4, in_bit4, word_ready4;
  logic [7:0] word_data4;
  logic [3:0] word_ones4;
  logic       word_valid4, overflow4;
  logic [3:0] hit_total4;
  logic [1:0] fill_state4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mealy_out_packer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .word_data(word_data), .word_ones(word_ones),
    .word_valid(word_valid), .word_ready(word_ready),
    .hit_total(hit_total), .overflow(overflow),
    .fill_state(fill_state)
  );

  mealy_out_packer #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_bit(in_bit4),
    .word_data(word_data4), .word_ones(word_ones4),
    .word_valid(word_valid4), .word_ready(word_ready4),
    .hit_total(hit_total4), .overflow(overflow4),
    .fill_state(fill_state4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive at a negedge, advance one full cycle to the next negedge
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [1:0] exp_fs(input int k);
    if (k == 0 || k == 8) return 2'd0;
    if (k == 7) return 2'd2;
    return 2'd1;
  endfunction

  logic [7:0] pat5;
  logic [7:0] pat81;
  int nidle;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; word_ready = 1'b0;
    rst4 = 1'b1; in_valid4 = 1'b0; in_bit4 = 1'b0; word_ready4 = 1'b1;
    @(negedge clk);

    // reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_hit", hit_total, 8'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_fs", fill_state, 2'd0);
    chk("rst_data", word_data, 8'd0);
    rst = 1'b0;

    // basic word, latency one cycle
    word_ready = 1'b1;
    send_word(8'hB2);
    chk("b2_data", word_data, 8'hB2);
    chk("b2_ones", word_ones, 4'd4);
    chk("b2_valid", word_valid, 1'b1);
    chk("b2_hit", hit_total, 8'd4);
    chk("b2_fs", fill_state, 2'd0);
    step(1'b0, 1'b0);
    chk("b2_accepted", word_valid, 1'b0);

    // overflow with stalled consumer
    do_reset();
    word_ready = 1'b0;
    send_word(8'hFF);
    chk("ff_valid", word_valid, 1'b1);
    chk("ff_ovf0", overflow, 1'b0);
    send_word(8'h0F);
    chk("ovf_data", word_data, 8'hFF);
    chk("ovf_ones", word_ones, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_hit", hit_total, 8'd12);
    step(1'b0, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_hold", word_valid, 1'b1);

    // back-to-back: accept on the completing cycle
    do_reset();
    chk("rst_clears_ovf", overflow, 1'b0);
    word_ready = 1'b0;
    send_word(8'h00);
    chk("b2b_first", word_valid, 1'b1);
    pat81 = 8'h81;
    for (int i = 7; i >= 1; i--) step(1'b1, pat81[i]);
    chk("b2b_hold", word_data, 8'h00);
    word_ready = 1'b1;
    step(1'b1, pat81[0]);
    word_ready = 1'b0;
    chk("b2b_valid", word_valid, 1'b1);
    chk("b2b_data", word_data, 8'h81);
    chk("b2b_ones", word_ones, 4'd2);
    chk("b2b_ovf", overflow, 1'b0);
    step(1'b0, 1'b0);
    chk("b2b_stable", word_data, 8'h81);
    chk("b2b_still_valid", word_valid, 1'b1);

    // reset while a word is held
    do_reset();
    chk("rst_drops_word", word_valid, 1'b0);
    chk("rst_data0", word_data, 8'd0);

    // gapped samples; FSM moves only on valid cycles
    word_ready = 1'b1;
    pat5 = 8'hF0;
    for (int k = 0; k < 8; k++) begin
      nidle = $urandom_range(0, 2);
      for (int j = 0; j < nidle; j++) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        chk("gap_fs", fill_state, exp_fs(k));
      end
      step(1'b1, pat5[7-k]);
      chk("gap_fs_step", fill_state, exp_fs(k+1));
    end
    chk("gap_data", word_data, 8'hF0);
    chk("gap_ones", word_ones, 4'd4);
    chk("gap_valid", word_valid, 1'b1);

    // reset mid-word leaves no stale bits
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("mid_fs", fill_state, 2'd1);
    do_reset();
    chk("mid_rst_fs", fill_state, 2'd0);
    chk("mid_rst_hit", hit_total, 8'd0);
    send_word(8'h3C);
    chk("mid_data", word_data, 8'h3C);
    chk("mid_ones", word_ones, 4'd4);
    chk("mid_hit", hit_total, 8'd4);

    // narrow counter saturation
    rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid4 = 1'b1;
      in_bit4   = 1'b1;
      @(negedge clk);
      if (i == 14) chk("sat_reach", hit_total4, 4'd15);
    end
    in_valid4 = 1'b0;
    chk("sat_hit", hit_total4, 4'd15);
    chk("sat_ovf", overflow4, 1'b0);
    chk("sat_fs", fill_state4, 2'd1);
    chk("sat_data", word_data4, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
